// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch front end: FSM encodings, reset PC
// default and the instruction codes the front end cares about.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,  // nothing outstanding
    ST_WAIT = 2'b01,  // one request outstanding, response is on-path
    ST_DROP = 2'b10,  // one request outstanding, response is wrong-path
    ST_HALT = 2'b11   // fetch stopped until reset
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [31:0] INST_NOP    = 32'h0000_0013;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/pc_fetch_unit_fetch_buffer.sv
// Two-entry FIFO of {pc, inst} pairs that absorbs imem responses while
// IF/ID is stalled. Push and pop may happen in the same cycle; clear wins.
module pc_fetch_unit_fetch_buffer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic [XLEN-1:0] push_inst,
  input  logic            pop,
  output logic [1:0]      count,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_inst
);

  logic [XLEN-1:0] pc_mem   [2];
  logic [XLEN-1:0] inst_mem [2];
  logic            rd_ptr;
  logic            wr_ptr;

  // Pointers and occupancy; clear empties the buffer in one edge.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Entry storage; contents are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      pc_mem[wr_ptr]   <= push_pc;
      inst_mem[wr_ptr] <= push_inst;
    end
  end

  assign head_pc   = pc_mem[rd_ptr];
  assign head_inst = inst_mem[rd_ptr];

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch front end: owns the fetch PC, issues one imem read at a time,
// buffers responses during stalls and fills the IF/ID register. Redirects
// from EX squash wrong-path work; EBREAK halts fetch until reset.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            halt_i,
  input  logic            stall_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            ifid_valid_o,
  output logic [XLEN-1:0] ifid_pc_o,
  output logic [XLEN-1:0] ifid_pc4_o,
  output logic [XLEN-1:0] ifid_inst_o,
  output logic            flush_o,
  output logic            halted_o
);

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~(XLEN'(3));
  endfunction

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] req_pc_q;

  logic            rsp;
  logic            kill;
  logic            load;
  logic            bypass;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_empty;
  logic [1:0]      fifo_count;
  logic [1:0]      count_after;
  logic            space;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_inst;

  // An accepted response only exists while an on-path request is outstanding.
  assign rsp         = (state_q == ST_WAIT) && imem_rvalid_i;
  assign kill        = halt_i || redirect_i;
  assign load        = !stall_i;
  assign fifo_empty  = (fifo_count == 2'd0);
  assign bypass      = load && rsp && fifo_empty;
  assign fifo_push   = rsp && !bypass && !kill;
  assign fifo_pop    = load && !fifo_empty && !kill;
  assign count_after = fifo_count + {1'b0, fifo_push} - {1'b0, fifo_pop};
  assign space       = (count_after < 2'd2);

  assign imem_addr_o = fetch_pc_q;
  assign halted_o    = (state_q == ST_HALT);
  assign flush_o     = redirect_i && !halted_o;

  pc_fetch_unit_fetch_buffer #(
    .XLEN (XLEN)
  ) u_fetch_buffer (
    .clk       (clk),
    .rst       (rst),
    .clear     (kill),
    .push      (fifo_push),
    .push_pc   (req_pc_q),
    .push_inst (imem_rdata_i),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .head_pc   (head_pc),
    .head_inst (head_inst)
  );

  // Next-state and request logic; a new request may overlap the response
  // of the previous one, so WAIT can stay in WAIT.
  always_comb begin
    state_d    = state_q;
    imem_req_o = 1'b0;
    if (!rst && (state_q == ST_IDLE || rsp) && space && !redirect_i && !halt_i)
      imem_req_o = 1'b1;
    if (state_q != ST_HALT) begin
      if (halt_i) begin
        state_d = ST_HALT;
      end else if (redirect_i) begin
        if (state_q == ST_WAIT || state_q == ST_DROP)
          state_d = imem_rvalid_i ? ST_IDLE : ST_DROP;
      end else if (imem_req_o) begin
        state_d = ST_WAIT;
      end else if (imem_rvalid_i && (state_q == ST_WAIT || state_q == ST_DROP)) begin
        state_d = ST_IDLE;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Fetch PC and IF/ID register; HALT freezes both with IF/ID empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      ifid_valid_o <= 1'b0;
      ifid_pc_o    <= '0;
      ifid_pc4_o   <= '0;
      ifid_inst_o  <= '0;
    end else if (state_q != ST_HALT) begin
      if (kill) begin
        ifid_valid_o <= 1'b0;
        if (!halt_i) fetch_pc_q <= word_align(redirect_pc_i);
      end else begin
        if (imem_req_o) fetch_pc_q <= fetch_pc_q + XLEN'(4);
        if (load) begin
          if (!fifo_empty) begin
            ifid_valid_o <= 1'b1;
            ifid_pc_o    <= head_pc;
            ifid_pc4_o   <= head_pc + XLEN'(4);
            ifid_inst_o  <= head_inst;
          end else if (rsp) begin
            ifid_valid_o <= 1'b1;
            ifid_pc_o    <= req_pc_q;
            ifid_pc4_o   <= req_pc_q + XLEN'(4);
            ifid_inst_o  <= imem_rdata_i;
          end else begin
            ifid_valid_o <= 1'b0;
          end
        end
      end
    end
  end

  // Remember the address of the outstanding request to tag its response.
  always_ff @(posedge clk) begin
    if (imem_req_o) req_pc_q <= fetch_pc_q;
  end

  // imem must never answer when nothing is outstanding.
  a_no_stray_rvalid: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid_i && (state_q == ST_IDLE || state_q == ST_HALT)));

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a behavioural in-order imem whose
// latency can be changed between phases (instruction word = its address).
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i  = 32'h0;
  logic        ifid_valid_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc4_o;
  logic [31:0] ifid_inst_o;
  logic        flush_o;
  logic        halted_o;

  int cyc     = 0;
  int lat     = 1;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  int t2_pc   [7] = '{8, 8, 8, 8, 12, 16, 20};
  int t2_req  [7] = '{1, 0, 0, 1, 1, 1, 1};
  int t2_addr [7] = '{16, 0, 0, 20, 24, 28, 32};

  pc_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .stall_i       (stall_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .ifid_valid_o  (ifid_valid_o),
    .ifid_pc_o     (ifid_pc_o),
    .ifid_pc4_o    (ifid_pc4_o),
    .ifid_inst_o   (ifid_inst_o),
    .flush_o       (flush_o),
    .halted_o      (halted_o)
  );

  always #5 clk = ~clk;

  // imem: record requests of this cycle, retire the response consumed this cycle
  always @(negedge clk) begin
    if (imem_rvalid_i && mq.size() > 0) mq.delete(0);
    if (imem_req_o) mq.push_back('{imem_addr_o, cyc + lat});
  end

  // imem: present the head response once its latency has elapsed
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mq[0].addr;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; halt_i = 1'b0;
    repeat (3) step();
    sample();
    check_eq("rst_req",    32'(imem_req_o),   32'd0);
    check_eq("rst_valid",  32'(ifid_valid_o), 32'd0);
    check_eq("rst_pc",     ifid_pc_o,         32'd0);
    check_eq("rst_pc4",    ifid_pc4_o,        32'd0);
    check_eq("rst_inst",   ifid_inst_o,       32'd0);
    check_eq("rst_halted", 32'(halted_o),     32'd0);

    // sequential fetch with 1-cycle imem
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) rst = 1'b0;
      sample();
      check_eq("t1_req",   32'(imem_req_o),   32'd1);
      check_eq("t1_addr",  imem_addr_o,       32'(4 * k));
      check_eq("t1_valid", 32'(ifid_valid_o), (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) begin
        check_eq("t1_pc",   ifid_pc_o,   32'(4 * (k - 2)));
        check_eq("t1_pc4",  ifid_pc4_o,  32'(4 * (k - 2) + 4));
        check_eq("t1_inst", ifid_inst_o, 32'(4 * (k - 2)));
      end
    end

    // stall for 3 cycles while IF/ID holds pc 8
    for (int i = 0; i < 7; i++) begin
      step();
      stall_i = (i < 3);
      if (i == 6) lat = 3;
      sample();
      check_eq("t2_valid", 32'(ifid_valid_o), 32'd1);
      check_eq("t2_pc",    ifid_pc_o,         32'(t2_pc[i]));
      check_eq("t2_req",   32'(imem_req_o),   32'(t2_req[i]));
      if (t2_req[i] != 0) check_eq("t2_addr", imem_addr_o, 32'(t2_addr[i]));
    end

    // redirect with a 3-cycle request in flight
    step(); sample();
    check_eq("t3_pc24", ifid_pc_o, 32'd24);
    step(); redirect_i = 1'b1; redirect_pc_i = 32'h100; sample();
    check_eq("t3_flush", 32'(flush_o),    32'd1);
    check_eq("t3_noreq", 32'(imem_req_o), 32'd0);
    check_eq("t3_pc28",  ifid_pc_o,       32'd28);
    step(); redirect_i = 1'b0; sample();
    check_eq("t3_drop_valid", 32'(ifid_valid_o), 32'd0);
    check_eq("t3_drop_req",   32'(imem_req_o),   32'd0);
    check_eq("t3_drop_flush", 32'(flush_o),      32'd0);
    step(); sample();
    check_eq("t3_newreq",  32'(imem_req_o), 32'd1);
    check_eq("t3_newaddr", imem_addr_o,     32'h100);
    for (int i = 0; i < 3; i++) begin
      step(); sample();
      check_eq("t3_nostale", 32'(ifid_valid_o), 32'd0);
    end
    check_eq("t3_addr104", imem_addr_o, 32'h104);

    // redirect and stall together, misaligned target
    step(); redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h203; lat = 1; sample();
    check_eq("t3_tgt_valid", 32'(ifid_valid_o), 32'd1);
    check_eq("t3_tgt_pc",    ifid_pc_o,         32'h100);
    check_eq("t3_tgt_inst",  ifid_inst_o,       32'h100);
    check_eq("t4_flush",     32'(flush_o),      32'd1);
    check_eq("t4_noreq",     32'(imem_req_o),   32'd0);
    step(); redirect_i = 1'b0; stall_i = 1'b0; sample();
    check_eq("t4_bubble", 32'(ifid_valid_o), 32'd0);
    check_eq("t4_req0",   32'(imem_req_o),   32'd0);
    step(); sample();
    check_eq("t4_req1", 32'(imem_req_o), 32'd0);
    step(); sample();
    check_eq("t4_req2",  32'(imem_req_o), 32'd1);
    check_eq("t4_align", imem_addr_o,     32'h200);
    step(); sample();
    check_eq("t4_addr204", imem_addr_o, 32'h204);
    step(); sample();
    check_eq("t4_valid", 32'(ifid_valid_o), 32'd1);
    check_eq("t4_pc",    ifid_pc_o,         32'h200);
    check_eq("t4_pc4",   ifid_pc4_o,        32'h204);

    // halt together with redirect
    step(); halt_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h300; sample();
    check_eq("t5_pc",    ifid_pc_o,       32'h204);
    check_eq("t5_flush", 32'(flush_o),    32'd1);
    check_eq("t5_noreq", 32'(imem_req_o), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step(); halt_i = 1'b0; redirect_i = (i == 5); sample();
      check_eq("t5_halt_req", 32'(imem_req_o), 32'd0);
      if (i == 0) begin
        check_eq("t5_halted", 32'(halted_o),     32'd1);
        check_eq("t5_valid",  32'(ifid_valid_o), 32'd0);
      end
      if (i == 5) check_eq("t5_noflush", 32'(flush_o), 32'd0);
    end
    step(); rst = 1'b1;
    step(); step();
    step(); rst = 1'b0; sample();
    check_eq("t5_unhalt", 32'(halted_o),    32'd0);
    check_eq("t5_req",    32'(imem_req_o),  32'd1);
    check_eq("t5_addr",   imem_addr_o,      32'h0);

    // wrap of the fetch PC
    step(); sample();
    check_eq("t6_addr4", imem_addr_o, 32'h4);
    step(); redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; sample();
    check_eq("t6_redir_req", 32'(imem_req_o), 32'd0);
    check_eq("t6_pc0",       ifid_pc_o,       32'h0);
    step(); redirect_i = 1'b0; sample();
    check_eq("t6_addr_top", imem_addr_o, 32'hFFFF_FFFC);
    step(); sample();
    check_eq("t6_wrap_req",  32'(imem_req_o), 32'd1);
    check_eq("t6_wrap_addr", imem_addr_o,     32'h0);
    step(); lat = 3; sample();
    check_eq("t6_top_pc",   ifid_pc_o,   32'hFFFF_FFFC);
    check_eq("t6_top_pc4",  ifid_pc4_o,  32'h0);
    check_eq("t6_top_inst", ifid_inst_o, 32'hFFFF_FFFC);

    // reset while a request is outstanding; its response lands during reset
    step(); rst = 1'b1; sample();
    check_eq("t6_rst_req", 32'(imem_req_o), 32'd0);
    repeat (3) step();
    step(); rst = 1'b0; sample();
    check_eq("t6_first_req",  32'(imem_req_o),   32'd1);
    check_eq("t6_first_addr", imem_addr_o,       32'h0);
    check_eq("t6_first_valid", 32'(ifid_valid_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(); sample();
      check_eq("t6_nolate", 32'(ifid_valid_o), 32'd0);
    end
    step(); sample();
    check_eq("t6_valid", 32'(ifid_valid_o), 32'd1);
    check_eq("t6_pc",    ifid_pc_o,         32'h0);
    check_eq("t6_inst",  ifid_inst_o,       32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
